// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the async-FIFO read-side drain stage.
// Holds the skid occupancy states, skid depth and default word width.
package fifo_rd_pkg;

  localparam int SKID_DEPTH = 2;
  localparam int DATA_SIZE_DEF = 9;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } occ_state_e;

endpackage

// File: rtl/fifo_rd_drain_if.sv
// FIFO read port plus valid/ready stream bundle for fifo_rd_drain.
// slave: drain stage view; master: FIFO + consumer (environment) view.
interface fifo_rd_drain_if
  import fifo_rd_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF
) ();

  logic                 drain_en;
  logic                 rEmpty;
  logic [DATA_SIZE-1:0] rData;
  logic                 rinc;
  logic                 m_valid;
  logic [DATA_SIZE-1:0] m_data;
  logic                 m_ready;

  modport slave (
    input  drain_en,
    input  rEmpty,
    input  rData,
    input  m_ready,
    output rinc,
    output m_valid,
    output m_data
  );

  modport master (
    output drain_en,
    output rEmpty,
    output rData,
    output m_ready,
    input  rinc,
    input  m_valid,
    input  m_data
  );

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer: push at tail, pop at head, occupancy FSM.
// Ports: rclk, rrst (async low), i_push/i_data, i_pop, o_valid/o_data/o_occ.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic                 i_push,
  input  logic [DATA_SIZE-1:0] i_data,
  input  logic                 i_pop,
  output logic                 o_valid,
  output logic [DATA_SIZE-1:0] o_data,
  output logic [1:0]           o_occ
);

  logic [DATA_SIZE-1:0] r_mem [SKID_DEPTH];
  logic                 r_head;
  logic                 r_tail;
  occ_state_e           r_state;
  occ_state_e           w_state_nxt;
  logic                 w_push;

  // a push into a full buffer without a pop is never issued upstream;
  // dropping it here keeps the stored words intact regardless
  assign w_push = i_push && (r_state != S_FULL || i_pop);

  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_EMPTY: begin
        if (w_push) w_state_nxt = S_ONE;
      end
      S_ONE: begin
        if (w_push && !i_pop) w_state_nxt = S_FULL;
        else if (!w_push && i_pop) w_state_nxt = S_EMPTY;
      end
      S_FULL: begin
        if (!w_push && i_pop) w_state_nxt = S_ONE;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) begin
      for (int i = 0; i < SKID_DEPTH; i++) r_mem[i] <= '0;
      r_head <= 1'b0;
      r_tail <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= i_data;
        r_tail <= ~r_tail;
      end
      if (i_pop) r_head <= ~r_head;
    end
  end

  assign o_valid = (r_state != S_EMPTY);
  assign o_data  = r_mem[r_head];
  assign o_occ   = r_state;

endmodule

// File: rtl/fifo_rd_drain.sv
// Async FIFO read-side drain: issues rinc on credit, absorbs the 1-cycle
// read latency and streams words out via a 2-entry skid buffer.
// Ports: rclk, rrst (async low), bus (fifo_rd_drain_if.slave);
// with FIFO_RD_STATS_EN also rd_cnt_clr / rd_word_cnt.
module fifo_rd_drain
  import fifo_rd_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 rclk,
  input  logic                 rrst,
  fifo_rd_drain_if.slave       bus
`ifdef FIFO_RD_STATS_EN
  ,
  input  logic                 rd_cnt_clr,
  output logic [CNT_WIDTH-1:0] rd_word_cnt
`endif
);

  logic                 r_infl;
  logic                 w_pop;
  logic                 w_valid;
  logic                 w_rinc;
  logic [1:0]           w_occ;
  logic [2:0]           w_need;
  logic [DATA_SIZE-1:0] w_data;

  assign w_pop = w_valid && bus.m_ready;

  // slots committed at the end of this cycle; a new read may issue
  // only if its data will find a free slot when it lands next cycle
  assign w_need = {1'b0, w_occ} + {2'b00, r_infl}
                - {2'b00, w_pop};

  assign w_rinc = rrst && bus.drain_en && !bus.rEmpty
               && (w_need <= 3'd1);

  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) begin
      r_infl <= 1'b0;
    end else begin
      r_infl <= w_rinc && !bus.rEmpty;
    end
  end

  fifo_rd_skid #(
    .DATA_SIZE (DATA_SIZE)
  ) u_skid (
    .rclk    (rclk),
    .rrst    (rrst),
    .i_push  (r_infl),
    .i_data  (bus.rData),
    .i_pop   (w_pop),
    .o_valid (w_valid),
    .o_data  (w_data),
    .o_occ   (w_occ)
  );

  assign bus.rinc    = w_rinc;
  assign bus.m_valid = w_valid;
  assign bus.m_data  = w_data;

`ifdef FIFO_RD_STATS_EN
  logic [CNT_WIDTH-1:0] r_cnt;

  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) begin
      r_cnt <= '0;
    end else if (rd_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_pop) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign rd_word_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: FIFO model with 1-cycle read latency,
// scoreboard queue of pushed words, per-scenario tasks.
module tb_fifo_rd_drain;
  import fifo_rd_pkg::*;

  localparam int DW = 9;
`ifdef FIFO_RD_STATS_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  logic rclk = 1'b0;
  logic rrst = 1'b0;

  fifo_rd_drain_if #(.DATA_SIZE(DW)) bus ();

`ifdef FIFO_RD_STATS_EN
  logic          rd_cnt_clr;
  logic [CW-1:0] rd_word_cnt;
`endif

  fifo_rd_drain #(
    .DATA_SIZE (DW),
    .CNT_WIDTH (CW)
  ) dut (
    .rclk        (rclk),
    .rrst        (rrst),
    .bus         (bus.slave)
`ifdef FIFO_RD_STATS_EN
    ,
    .rd_cnt_clr  (rd_cnt_clr),
    .rd_word_cnt (rd_word_cnt)
`endif
  );

  always #5 rclk = ~rclk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] exp_q  [$];
  logic [DW-1:0] e;
  logic [DW-1:0] prev_data;
  logic          prev_hold = 1'b0;
  logic          rinc_s = 1'b0;
  logic          m_infl = 1'b0;
  int            m_occ = 0;
  int n_rd = 0, n_pop = 0, n_rinc = 0, n_drop = 0;
  int cyc = 0;
  int first_rinc = -1, last_rinc = -1;
  int first_valid = -1, last_pop = -1;

  // consumer-side monitor and scoreboard
  always @(negedge rclk) begin
    cyc++;
    if (!rrst) begin
      rinc_s = 1'b0;
      m_occ = 0;
      m_infl = 1'b0;
      prev_hold = 1'b0;
    end else begin
      rinc_s = bus.rinc;
      if (bus.rinc) begin
        n_rinc++;
        last_rinc = cyc;
        if (first_rinc < 0) first_rinc = cyc;
      end
      if (bus.m_valid && first_valid < 0) first_valid = cyc;
      checks++;
      if (bus.rinc && bus.rEmpty) begin
        errors++;
        $display("FAIL rinc_empty got=1 exp=0 cyc=%0d", cyc);
      end
      checks++;
      if (bus.m_valid !== (m_occ != 0)) begin
        errors++;
        $display("FAIL m_valid got=%b exp=%b cyc=%0d",
                 bus.m_valid, (m_occ != 0), cyc);
      end
      if (prev_hold) begin
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== prev_data) begin
          errors++;
          $display("FAIL hold got=%b/%0h exp=1/%0h",
                   bus.m_valid, bus.m_data, prev_data);
        end
      end
      if (bus.m_valid && bus.m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat got=%0h exp=none", bus.m_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.m_data !== e) begin
            errors++;
            $display("FAIL order got=%0h exp=%0h", bus.m_data, e);
          end
        end
        n_pop++;
        last_pop = cyc;
      end
      m_occ = m_occ + int'(m_infl)
            - int'(bus.m_valid && bus.m_ready);
      checks++;
      if (m_occ > 2) begin
        errors++;
        $display("FAIL overflow got=%0d exp<=2", m_occ);
      end
      m_infl = bus.rinc && !bus.rEmpty;
      prev_hold = bus.m_valid && !bus.m_ready;
      prev_data = bus.m_data;
    end
  end

  // FIFO model: registered read data, registered empty flag
  always @(posedge rclk) begin
    #2;
    if (rinc_s && rrst && fifo_q.size() > 0) begin
      bus.rData = fifo_q.pop_front();
      n_rd++;
    end
    bus.rEmpty = (fifo_q.size() == 0);
  end

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic wait_pops(input int target, input int budget);
    int k = 0;
    while (n_pop < target && k < budget) begin
      step();
      k++;
    end
    checks++;
    if (n_pop < target) begin
      errors++;
      $display("FAIL timeout got=%0d exp=%0d", n_pop, target);
    end
  endtask

  task automatic test_reset();
    bus.drain_en = 1'b1;
    push_word(9'h0AA);
    repeat (3) step();
    checks++;
    if (bus.rinc !== 1'b0 || bus.m_valid !== 1'b0
        || bus.m_data !== '0) begin
      errors++;
      $display("FAIL reset got=%b/%b/%0h exp=0/0/0",
               bus.rinc, bus.m_valid, bus.m_data);
    end
    rrst = 1'b1;
    bus.m_ready = 1'b1;
    wait_pops(1, 20);
  endtask

  task automatic test_stream();
    int r0;
    bus.drain_en = 1'b0;
    bus.m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push_word(DW'(i));
    repeat (2) step();
    r0 = n_rinc;
    first_rinc = -1;
    first_valid = -1;
    bus.drain_en = 1'b1;
    wait_pops(n_pop + 8, 40);
    checks++;
    if (first_valid - first_rinc !== 2) begin
      errors++;
      $display("FAIL latency got=%0d exp=2",
               first_valid - first_rinc);
    end
    checks++;
    if (last_pop - first_valid !== 7) begin
      errors++;
      $display("FAIL beats got=%0d exp=7", last_pop - first_valid);
    end
    checks++;
    if (n_rinc - r0 !== 8 || last_rinc - first_rinc !== 7) begin
      errors++;
      $display("FAIL rinc_run got=%0d/%0d exp=8/7",
               n_rinc - r0, last_rinc - first_rinc);
    end
  endtask

  task automatic test_backpressure();
    int r0, base;
    bus.drain_en = 1'b0;
    bus.m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push_word(DW'(i));
    repeat (2) step();
    r0 = n_rinc;
    base = n_pop;
    bus.drain_en = 1'b1;
    repeat (6) step();
    checks++;
    if (n_rinc - r0 !== 2) begin
      errors++;
      $display("FAIL bp_rinc got=%0d exp=2", n_rinc - r0);
    end
    checks++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 9'h001) begin
      errors++;
      $display("FAIL bp_head got=%b/%0h exp=1/1",
               bus.m_valid, bus.m_data);
    end
    bus.m_ready = 1'b1;
    wait_pops(base + 8, 40);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL bp_left got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_toggle();
    int base, k;
    bus.drain_en = 1'b0;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 32; i++) push_word(DW'($urandom_range(0, 511)));
    step();
    base = n_pop;
    bus.drain_en = 1'b1;
    k = 0;
    while (n_pop < base + 32 && k < 200) begin
      bus.m_ready = ~bus.m_ready;
      step();
      k++;
    end
    bus.m_ready = 1'b1;
    wait_pops(base + 32, 10);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL tog_left got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_drain_stop();
    int r0, base;
    bus.drain_en = 1'b0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(DW'(9'h100 + i));
    repeat (2) step();
    r0 = n_rinc;
    base = n_pop;
    bus.drain_en = 1'b1;
    step();
    bus.drain_en = 1'b0;
    repeat (6) step();
    checks++;
    if (n_pop - base !== 1) begin
      errors++;
      $display("FAIL stop_pop got=%0d exp=1", n_pop - base);
    end
    checks++;
    if (n_rinc - r0 !== 1) begin
      errors++;
      $display("FAIL stop_rinc got=%0d exp=1", n_rinc - r0);
    end
    bus.drain_en = 1'b1;
    wait_pops(base + 4, 20);
  endtask

  task automatic test_rst_mid();
    int drop;
    bus.drain_en = 1'b0;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(DW'(9'h1A0 + i));
    repeat (2) step();
    bus.drain_en = 1'b1;
    repeat (5) step();
    checks++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 9'h1A0) begin
      errors++;
      $display("FAIL pre_rst got=%b/%0h exp=1/1a0",
               bus.m_valid, bus.m_data);
    end
    rrst = 1'b0;
    #1;
    checks++;
    if (bus.m_valid !== 1'b0 || bus.rinc !== 1'b0
        || bus.m_data !== '0) begin
      errors++;
      $display("FAIL async_rst got=%b/%b/%0h exp=0/0/0",
               bus.m_valid, bus.rinc, bus.m_data);
    end
    drop = n_rd - n_pop - n_drop;
    n_drop += drop;
    repeat (drop) e = exp_q.pop_front();
    repeat (2) step();
    rrst = 1'b1;
    bus.m_ready = 1'b1;
    wait_pops(n_pop + 3, 20);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL rst_left got=%0d exp=0", exp_q.size());
    end
  endtask

`ifdef FIFO_RD_STATS_EN
  task automatic test_stats();
    int k;
    bus.drain_en = 1'b1;
    bus.m_ready = 1'b1;
    rd_cnt_clr = 1'b1;
    step();
    rd_cnt_clr = 1'b0;
    for (int i = 0; i < 10; i++) push_word(DW'(9'h40 + i));
    wait_pops(n_pop + 10, 40);
    step();
    checks++;
    if (rd_word_cnt !== CW'(10)) begin
      errors++;
      $display("FAIL cnt10 got=%0d exp=10", rd_word_cnt);
    end
    push_word(9'h055);
    k = 0;
    @(negedge rclk);
    while (!bus.m_valid && k < 20) begin
      @(negedge rclk);
      k++;
    end
    rd_cnt_clr = 1'b1;
    step();
    rd_cnt_clr = 1'b0;
    checks++;
    if (rd_word_cnt !== '0) begin
      errors++;
      $display("FAIL cnt_clr got=%0d exp=0", rd_word_cnt);
    end
    for (int i = 0; i < 17; i++) push_word(DW'(9'h60 + i));
    wait_pops(n_pop + 17, 60);
    step();
    checks++;
    if (rd_word_cnt !== CW'(1)) begin
      errors++;
      $display("FAIL cnt_wrap got=%0d exp=1", rd_word_cnt);
    end
  endtask
`endif

  initial begin
    bus.drain_en = 1'b0;
    bus.m_ready = 1'b0;
    bus.rEmpty = 1'b1;
    bus.rData = '0;
`ifdef FIFO_RD_STATS_EN
    rd_cnt_clr = 1'b0;
`endif
    test_reset();
    test_stream();
    test_backpressure();
    test_toggle();
    test_drain_stop();
    test_rst_mid();
`ifdef FIFO_RD_STATS_EN
    test_stats();
`endif
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_rd_drain.md
Name: fifo_rd_drain

Overview:
- Read-side drain stage that sits directly downstream of the async FIFO, in the rclk domain.
- Drives the FIFO's rinc from rEmpty and absorbs the FIFO's one-cycle registered read latency.
- Captures rData into a 2-entry skid buffer and presents a valid/ready stream to the read-side consumer at one word per cycle sustained.

Parameters:
DATA_SIZE, 9, width of FIFO words / stream data
CNT_WIDTH, 16, width of delivered-word counter (used only with FIFO_RD_STATS_EN)

Ports:
rclk  input  1  read clock; all logic posedge rclk
rrst  input  1  read reset, asynchronous, active-low
drain_en  input  1  permit issuing new FIFO reads
rEmpty  input  1  FIFO empty flag (registered, rclk domain)
rData  input  DATA_SIZE  FIFO read data, valid the cycle after an accepted rinc
rinc  output  1  FIFO read enable
m_valid  output  1  stream data valid
m_data  output  DATA_SIZE  stream data (head of skid buffer)
m_ready  input  1  consumer accepts when m_valid && m_ready
rd_cnt_clr  input  1  synchronous clear of rd_word_cnt (FIFO_RD_STATS_EN only)
rd_word_cnt  output  CNT_WIDTH  words delivered (FIFO_RD_STATS_EN only)

Behaviour:
- Interface fixed: one clock rclk; reset rrst is asynchronous, active-low.
- Reset values:
  - rinc=0 (forced 0 while rrst low), m_valid=0, m_data=0.
  - Occupancy=0, inflight=0, buffer entries=0, rd_word_cnt=0.
- Definitions:
  - pop = m_valid && m_ready.
  - inflight = registered rinc && !rEmpty from the previous cycle.
- rinc = drain_en && !rEmpty && (occ + inflight - pop <= 1). This is combinational from registers plus m_ready; rinc never asserts while rEmpty=1.
- Capture: when inflight=1, rData is written to the tail of the buffer at the end of that cycle.
- Timing:
  - rinc in cycle N gives capture at end of N+1 and m_valid in N+2. First-word latency is 2 cycles from rinc.
  - With m_ready held high, steady state is occ=1, inflight=1, pop=1, so rinc stays high and throughput is one word per cycle.
- Occupancy FSM (occ 0..2): S_EMPTY, S_ONE, S_FULL.
  - Next occ = occ + inflight - pop.
  - Simultaneous push and pop keeps the state; head and tail advance together.
  - S_FULL is reachable only when m_ready is low. The rinc rule guarantees no push arrives when occ=2 and pop=0. Overflow is impossible; the bench asserts it.
- Ordering: strict FIFO order; m_data = oldest entry. m_data holds stable while m_valid && !m_ready.
- m_valid = (occ != 0). It never drops without a pop.
- drain_en deassert: stops new rinc the same cycle. Any inflight word is still captured and delivered. Buffered words are still drained.
- rEmpty assert mid-stream: rinc drops that cycle; prior inflight is still captured.
- Reset mid-operation: buffered and inflight data are discarded. The FIFO pointer is already advanced for any inflight read, so that word is lost by design.

Optional Feature:
FIFO_RD_STATS_EN
- Defined:
  - rd_cnt_clr and rd_word_cnt ports exist.
  - rd_word_cnt increments on each pop and wraps at 2^CNT_WIDTH.
  - rd_cnt_clr loads 0 and has priority over the increment, giving 0 that cycle.
- Undefined: both ports and the counter are absent; no other behaviour changes.

Decomposition:
- Package fifo_rd_pkg holds:
  - occ_state_e enum (S_EMPTY, S_ONE, S_FULL).
  - localparam SKID_DEPTH=2.
  - Default DATA_SIZE=9 constant shared with the FIFO.
- One sub-module, fifo_rd_skid: a 2-entry buffer with push/pop, head/tail index, occ, and m_data.
- fifo_rd_drain holds the rinc credit logic, the inflight register, and the optional counter.

Test Plan:
- Preload FIFO with 0x001..0x008, drain_en=1, m_ready=1 -> first m_valid 2 cycles after first rinc; 8 consecutive beats 0x001..0x008; rinc continuous for 8 cycles.
- Same 8 words, m_ready held 0 -> exactly 2 rinc pulses, occ=2, m_data=0x001 stable; release m_ready -> remaining words delivered in order with no loss or duplicate.
- m_ready toggling 1010… with 32 random words -> output sequence equals input; no overflow assertion fires; rinc never high with rEmpty=1.
- drain_en dropped the cycle after a rinc -> that inflight word is delivered; no further rinc until drain_en=1.
- rrst asserted with occ=2 -> m_valid=0 and rinc=0 immediately (asynchronous); after release, streaming resumes from the FIFO's next word.
- FIFO_RD_STATS_EN: 10 pops -> rd_word_cnt=10; rd_cnt_clr coincident with a pop -> 0; with CNT_WIDTH=4, 17 pops -> 1.
